// File: rtl/core_run_ctrl_if.sv
// Data-memory bus bundle for core_run_ctrl: host loader, core request lines and the memory port.
// slave modport is taken by the controller, master by the surrounding environment.
interface core_run_ctrl_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic [DATA_W-1:0] host_rdata;

  logic              core_mem_read;
  logic              core_mem_write;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rdata,
    input  core_mem_read, core_mem_write, core_addr, core_wdata,
    output core_rdata,
    output mem_addr, mem_wdata, mem_write, mem_read,
    input  mem_rdata
  );

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rdata,
    output core_mem_read, core_mem_write, core_addr, core_wdata,
    input  core_rdata,
    input  mem_addr, mem_wdata, mem_write, mem_read,
    output mem_rdata
  );
endinterface

// File: rtl/core_run_ctrl.sv
// Run controller and data-memory arbiter for the miniMips core (IDLE/PRIME/RUN/FINISH).
// Optional `STEP_MODE_EN adds step_i single-stepping in RUN. Bus widths come from core_run_ctrl_if.
module core_run_ctrl #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 32'h0000_FFFF
) (
  input  logic             clk,
  input  logic             start,
  input  logic             go_i,
`ifdef STEP_MODE_EN
  input  logic             step_i,
`endif
  input  logic             core_done_i,
  core_run_ctrl_if.slave   bus,
  output logic             core_rst_o,
  output logic             core_en_o,
  output logic             busy_o,
  output logic             finished_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] cycle_count_o
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, FINISH} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fin_q, fin_d;
  logic             to_q, to_d;
  logic             host_sel_c, core_sel_c, adv_c;

`ifdef STEP_MODE_EN
  assign adv_c = step_i;
`else
  assign adv_c = 1'b1;
`endif

  always_ff @(posedge clk or posedge start) begin
    if (start) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fin_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fin_q   <= fin_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fin_d      = fin_q;
    to_d       = to_q;
    core_rst_o = 1'b1;
    core_en_o  = 1'b0;
    busy_o     = 1'b0;
    host_sel_c = 1'b0;
    core_sel_c = 1'b0;
    case (state_q)
      IDLE: begin
        host_sel_c = ~start;
        if (go_i && !bus.host_req) state_d = PRIME;
      end
      PRIME: begin
        busy_o  = 1'b1;
        cnt_d   = '0;
        fin_d   = 1'b0;
        to_d    = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        busy_o     = 1'b1;
        core_rst_o = 1'b0;
        core_en_o  = adv_c;
        core_sel_c = 1'b1;
        if (adv_c) begin
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
          // done takes precedence over a watchdog expiring in the same cycle
          if (core_done_i) begin
            fin_d   = 1'b1;
            state_d = FINISH;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            fin_d   = 1'b1;
            to_d    = 1'b1;
            state_d = FINISH;
          end
        end
      end
      FINISH: begin
        core_rst_o = 1'b0;
        host_sel_c = 1'b1;
        if (!go_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory routing: host while idle/finished, core while running, nothing in PRIME.
  assign bus.host_gnt   = host_sel_c & bus.host_req;
  assign bus.mem_addr   = host_sel_c ? bus.host_addr  : bus.core_addr;
  assign bus.mem_wdata  = host_sel_c ? bus.host_wdata : bus.core_wdata;
  assign bus.mem_write  = (host_sel_c & bus.host_req & bus.host_we)
                        | (core_sel_c & bus.core_mem_write);
  assign bus.mem_read   = (host_sel_c & bus.host_req & ~bus.host_we)
                        | (core_sel_c & bus.core_mem_read);
  assign bus.host_rdata = bus.mem_rdata;
  assign bus.core_rdata = bus.mem_rdata;

  assign finished_o    = fin_q;
  assign timeout_o     = to_q;
  assign cycle_count_o = cnt_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Self-checking bench for core_run_ctrl: host-access vector table, hand sequences for the
// multi-cycle corners, and randomized runs checked against a run-outcome model.
module tb_core_run_ctrl;
  localparam int unsigned TO = 20;

  logic        clk = 1'b0;
  logic        start = 1'b1;
  logic        go = 1'b0;
  logic        core_done = 1'b0;
  logic        core_rst, core_en, busy, finished, timeout;
  logic [15:0] cycle_count;
`ifdef STEP_MODE_EN
  logic        step = 1'b1;
`endif

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] mem [256];

  core_run_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  core_run_ctrl #(.CNT_W(16), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .start         (start),
    .go_i          (go),
`ifdef STEP_MODE_EN
    .step_i        (step),
`endif
    .core_done_i   (core_done),
    .bus           (bus),
    .core_rst_o    (core_rst),
    .core_en_o     (core_en),
    .busy_o        (busy),
    .finished_o    (finished),
    .timeout_o     (timeout),
    .cycle_count_o (cycle_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
  assign bus.mem_rdata = mem[bus.mem_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bus();
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    bus.core_mem_read = 1'b0; bus.core_mem_write = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
  endtask

  // Pulse go from IDLE, raise core_done on RUN cycle done_at (0 = never), stop on reaching FINISH.
  task automatic run_prog(input int done_at, input bit rnd, output int busy_n, output int run_n,
                          output bit ok);
    logic wr;
    busy_n = 0; run_n = 0; ok = 1'b0;
    go = 1'b1;
    for (int k = 0; k < 200; k++) begin
      step_clk();
      go = 1'b0; core_done = 1'b0; bus.host_req = 1'b0; bus.core_mem_write = 1'b0;
      if (busy) busy_n++;
      if (core_en) begin
        run_n++;
        core_done = (run_n == done_at);
        if (rnd) begin
          wr = 1'($urandom);
          bus.host_req = 1'($urandom); bus.host_we = 1'b1;
          bus.core_mem_write = wr; bus.core_addr = 8'($urandom); bus.core_wdata = 8'($urandom);
          #1;
          chk("run_host_gnt", 32'(bus.host_gnt), 32'd0);
          chk("run_mem_write", 32'(bus.mem_write), 32'(wr));
        end
      end
      if (finished && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    core_done = 1'b0;
    clear_bus();
    if (!ok) chk("run_reaches_finish", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic       req, we;
    logic [7:0] addr, wdata;
    logic       e_gnt, e_wr, e_rd;
    logic       chk_rd;
    logic [7:0] e_rdata;
  } vec_t;

  initial begin
    vec_t vecs [6];
    int   busy_n, run_n, r, exp_cnt;
    bit   ok, exp_to;
    int   done_at;
    logic [7:0] sb [logic [7:0]];
    logic [7:0] a, d;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    clear_bus();

    vecs[0] = '{1'b1, 1'b1, 8'h10, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 1'b1, 8'h20, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[2] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5};
    vecs[3] = '{1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C};
    vecs[4] = '{1'b0, 1'b1, 8'h10, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[5] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5};

    // Reset values, including no grant while reset is held
    #2;
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_core_en", 32'(core_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_finished", 32'(finished), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_count", 32'(cycle_count), 32'd0);
    bus.host_req = 1'b1; #1;
    chk("rst_host_gnt", 32'(bus.host_gnt), 32'd0);
    bus.host_req = 1'b0;
    step_clk();
    start = 1'b0;
    step_clk();

    // Host load/readback table in IDLE
    foreach (vecs[i]) begin
      bus.host_req = vecs[i].req; bus.host_we = vecs[i].we;
      bus.host_addr = vecs[i].addr; bus.host_wdata = vecs[i].wdata;
      #1;
      chk($sformatf("vec%0d_gnt", i), 32'(bus.host_gnt), 32'(vecs[i].e_gnt));
      chk($sformatf("vec%0d_wr", i), 32'(bus.mem_write), 32'(vecs[i].e_wr));
      chk($sformatf("vec%0d_rd", i), 32'(bus.mem_read), 32'(vecs[i].e_rd));
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), 32'(bus.host_rdata), 32'(vecs[i].e_rdata));
      step_clk();
    end
    clear_bus();

    // Normal run, done on 7th RUN cycle
    run_prog(7, 1'b0, busy_n, run_n, ok);
    chk("norm_busy_cycles", 32'(busy_n), 32'd8);
    chk("norm_finished", 32'(finished), 32'd1);
    chk("norm_timeout", 32'(timeout), 32'd0);
    chk("norm_count", 32'(cycle_count), 32'd7);
    step_clk();

    // Watchdog
    run_prog(0, 1'b0, busy_n, run_n, ok);
    chk("wd_run_cycles", 32'(run_n), 32'(TO));
    chk("wd_timeout", 32'(timeout), 32'd1);
    chk("wd_count", 32'(cycle_count), 32'(TO));
    chk("wd_core_en", 32'(core_en), 32'd0);
    step_clk();

    // Done and watchdog in the same cycle: done wins
    run_prog(int'(TO), 1'b0, busy_n, run_n, ok);
    chk("tie_timeout", 32'(timeout), 32'd0);
    chk("tie_count", 32'(cycle_count), 32'(TO));
    step_clk();

    // Arbitration: host_req blocks go
    go = 1'b1; bus.host_req = 1'b1; bus.host_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step_clk();
      chk("arb_blocked_busy", 32'(busy), 32'd0);
    end
    bus.host_req = 1'b0;
    step_clk();
    chk("arb_prime_busy", 32'(busy), 32'd1);
    chk("arb_prime_core_rst", 32'(core_rst), 32'd1);
    go = 1'b0;
    step_clk();
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.core_mem_write = 1'b0; #1;
    chk("arb_run_gnt", 32'(bus.host_gnt), 32'd0);
    chk("arb_run_nowr", 32'(bus.mem_write), 32'd0);
    bus.core_mem_write = 1'b1; bus.core_addr = 8'h44; #1;
    chk("arb_run_corewr", 32'(bus.mem_write), 32'd1);
    chk("arb_run_addr", 32'(bus.mem_addr), 32'h44);
    core_done = 1'b1;
    step_clk();
    core_done = 1'b0; clear_bus();
    chk("arb_finished", 32'(finished), 32'd1);
    step_clk();

    // Level go held through FINISH, then rerun
    go = 1'b1;
    step_clk();
    step_clk();
    core_done = 1'b1;
    step_clk();
    core_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step_clk();
      chk("lvl_hold_finish", 32'({finished, busy, core_rst}), 32'b100);
    end
    go = 1'b0;
    step_clk();
    chk("lvl_idle_core_rst", 32'(core_rst), 32'd1);
    go = 1'b1;
    step_clk();
    go = 1'b0;
    step_clk();
    chk("lvl_rerun_finished", 32'(finished), 32'd0);
    chk("lvl_rerun_count", 32'(cycle_count), 32'd0);
    chk("lvl_rerun_en", 32'(core_en), 32'd1);
    core_done = 1'b1;
    step_clk();
    core_done = 1'b0;
    step_clk();

    // Asynchronous reset on RUN cycle 5 with a core write in flight
    go = 1'b1;
    r = 0;
    for (int i = 0; i < 20 && r < 5; i++) begin
      step_clk();
      go = 1'b0;
      if (core_en) r++;
    end
    chk("ar_reached_run5", 32'(r), 32'd5);
    bus.core_mem_write = 1'b1; #1;
    chk("ar_pre_write", 32'(bus.mem_write), 32'd1);
    start = 1'b1; #1;
    chk("ar_core_rst", 32'(core_rst), 32'd1);
    chk("ar_core_en", 32'(core_en), 32'd0);
    chk("ar_mem_write", 32'(bus.mem_write), 32'd0);
    step_clk();
    start = 1'b0; clear_bus();
    step_clk();
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_count", 32'(cycle_count), 32'd0);
    chk("ar_finished", 32'(finished), 32'd0);

    // Randomized runs against the run-outcome model, with random idle host traffic
    for (int t = 0; t < 12; t++) begin
      sb.delete();
      for (int i = 0; i < 6; i++) begin
        a = 8'($urandom); d = 8'($urandom);
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = a; bus.host_wdata = d;
        step_clk();
        sb[a] = d;
      end
      foreach (sb[k]) begin
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = k; #1;
        chk("rnd_readback", 32'(bus.host_rdata), 32'(sb[k]));
        step_clk();
      end
      clear_bus();
      done_at = int'($urandom_range(0, TO + 5));
      exp_to  = !(done_at >= 1 && done_at <= int'(TO));
      exp_cnt = exp_to ? int'(TO) : done_at;
      run_prog(done_at, 1'b1, busy_n, run_n, ok);
      chk("rnd_count", 32'(cycle_count), 32'(exp_cnt));
      chk("rnd_timeout", 32'(timeout), 32'(exp_to));
      chk("rnd_busy_cycles", 32'(busy_n), 32'(exp_cnt + 1));
      step_clk();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
